// File: rtl/flag_sequencer.sv
// Flag selector sequencer: debounced next/prev buttons plus auto-cycle dwell,
// with selector updates applied only on frame_tick cycles.

module flag_btn_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, ARMING, HELD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    sync;
    logic          s;

    assign s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // press is only meaningful in the frame_tick cycle that accepts it
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press     = 1'b0;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (s) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_nxt = HELD;
                            press     = 1'b1;
                        end else begin
                            state_nxt = ARMING;
                            cnt_nxt   = CW'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!s) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CW'(DEBOUNCE_FRAMES - 1)) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        press     = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end
endmodule

module flag_sequencer #(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int DWELL_FRAMES    = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    input  logic [7:0] count,
    output logic [7:0] selector,
    output logic       flag_changed
);
    localparam int DW = $clog2(DWELL_FRAMES);

    logic [1:0]    btn_raw, btn_evt;
    logic          next_ev, prev_ev, manual, dwell_last, auto_ev, pulse;
    logic [DW-1:0] dwell, dwell_nxt;
    logic [7:0]    sel_nxt, sel_inc, sel_dec;

    assign btn_raw = {btn_prev, btn_next};

    for (genvar i = 0; i < 2; i++) begin : g_btn
        flag_btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .btn        (btn_raw[i]),
            .press      (btn_evt[i])
        );
    end

    assign next_ev    = btn_evt[0];
    assign prev_ev    = btn_evt[1];
    assign manual     = next_ev | prev_ev;
    assign dwell_last = (dwell == DW'(DWELL_FRAMES - 1));
    assign auto_ev    = frame_tick & auto_en & ~manual & dwell_last;
    assign sel_inc    = (selector == count - 8'd1) ? 8'd0 : selector + 8'd1;
    assign sel_dec    = (selector == 8'd0) ? count - 8'd1 : selector - 8'd1;

    always_comb begin
        dwell_nxt = dwell;
        if (frame_tick) begin
            if (!auto_en || manual || dwell_last) dwell_nxt = '0;
            else                                  dwell_nxt = dwell + DW'(1);
        end
    end

    // A shrunken count is repaired before any button or auto event is honoured
    always_comb begin
        sel_nxt = selector;
        pulse   = 1'b0;
        if (frame_tick) begin
            if (count == 8'd0) begin
                sel_nxt = 8'd0;
            end else if (selector >= count) begin
                sel_nxt = 8'd0;
                pulse   = 1'b1;
            end else if (!(next_ev && prev_ev)) begin
                if (next_ev || auto_ev) begin
                    sel_nxt = sel_inc;
                    pulse   = 1'b1;
                end else if (prev_ev) begin
                    sel_nxt = sel_dec;
                    pulse   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            selector     <= 8'd0;
            flag_changed <= 1'b0;
            dwell        <= '0;
        end else begin
            selector     <= sel_nxt;
            flag_changed <= pulse;
            dwell        <= dwell_nxt;
        end
    end
endmodule
